// File: rtl/decoder_2_4_pipe.sv
// Registered 2-to-4 decoder for {V,Y} link codes with a single-entry valid/ready output stage
// and a saturating, software-clearable error counter for invalid codes.
module decoder_2_4_pipe #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             V,
  input  logic [1:0]       Y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       O,
  input  logic             err_clr,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {StEmpty, StFull} state_e;

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e           state_q, state_d;
  logic [3:0]       o_q, o_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       accept;
  logic       accept_ok;
  logic       accept_bad;
  logic [3:0] decoded;

  // Y=11 maps to the lowest bit: O = 1 << (3 - Y).
  always_comb begin
    decoded = 4'b0000;
    unique case (Y)
      2'b11:   decoded = 4'b0001;
      2'b10:   decoded = 4'b0010;
      2'b01:   decoded = 4'b0100;
      2'b00:   decoded = 4'b1000;
      default: decoded = 4'b0000;
    endcase
  end

  // Ready depends only on the output stage, never on in_valid.
  assign in_ready   = (state_q == StEmpty) || out_ready;
  assign accept     = in_valid && in_ready;
  assign accept_ok  = accept && V;
  assign accept_bad = accept && !V;

  always_comb begin
    state_d = state_q;
    o_d     = o_q;
    unique case (state_q)
      StEmpty: begin
        if (accept_ok) begin
          state_d = StFull;
          o_d     = decoded;
        end
      end
      StFull: begin
        if (out_ready) begin
          if (accept_ok) begin
            o_d = decoded;
          end else begin
            state_d = StEmpty;
            o_d     = 4'b0000;
          end
        end
      end
      default: begin
        state_d = StEmpty;
        o_d     = 4'b0000;
      end
    endcase
  end

  // Clear wins over a coinciding invalid accept; that error is dropped.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else if (accept_bad) begin
      err_d = 1'b1;
      if (cnt_q != CntMax) begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      o_q     <= 4'b0000;
    end else begin
      state_q <= state_d;
      o_q     <= o_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid = (state_q == StFull);
  assign O         = o_q;
  assign err       = err_q;
  assign err_cnt   = cnt_q;

endmodule

// File: tb/tb_decoder_2_4_pipe.sv
// Self-checking bench for decoder_2_4_pipe: directed scenarios plus random traffic against a
// behavioural model; two instances (CNT_W=8 and CNT_W=2) share all inputs.
module tb_decoder_2_4_pipe;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       V = 1'b0;
  logic [1:0] Y = 2'b00;
  logic       out_ready = 1'b0;
  logic       err_clr = 1'b0;

  logic       in_ready_a, out_valid_a, err_a;
  logic [3:0] o_a;
  logic [7:0] cnt_a;
  logic       in_ready_b, out_valid_b, err_b;
  logic [3:0] o_b;
  logic [1:0] cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model state
  bit m_valid;
  int m_o;
  bit m_err;
  int m_cnt8;
  int m_cnt2;

  decoder_2_4_pipe #(.CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a), .V(V), .Y(Y),
    .out_valid(out_valid_a), .out_ready(out_ready), .O(o_a), .err_clr(err_clr),
    .err(err_a), .err_cnt(cnt_a)
  );

  decoder_2_4_pipe #(.CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b), .V(V), .Y(Y),
    .out_valid(out_valid_b), .out_ready(out_ready), .O(o_b), .err_clr(err_clr),
    .err(err_b), .err_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_valid = 0; m_o = 0; m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
  endtask

  // Advance one clock edge and the model with it; inputs must already be driven.
  task automatic tick();
    bit rdy, acc;
    rdy = !m_valid || out_ready;
    acc = in_valid && rdy;
    @(posedge clk);
    if (err_clr) begin
      m_err = 0; m_cnt8 = 0; m_cnt2 = 0;
    end else if (acc && !V) begin
      m_err = 1;
      m_cnt8 = (m_cnt8 + 1 > 255) ? 255 : m_cnt8 + 1;
      m_cnt2 = (m_cnt2 + 1 > 3) ? 3 : m_cnt2 + 1;
    end
    if (acc && V) begin
      m_valid = 1; m_o = 1 << (3 - int'(Y));
    end else if (m_valid && out_ready) begin
      m_valid = 0; m_o = 0;
    end
    #1;
  endtask

  task automatic drive(input bit iv, input bit v, input bit [1:0] y, input bit ordy,
                       input bit clr);
    in_valid = iv; V = v; Y = y; out_ready = ordy; err_clr = clr;
  endtask

  task automatic test_reset();
    drive(0, 0, 2'b00, 0, 0);
    rst_n = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if ({out_valid_a, o_a, err_a, cnt_a} !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_a: got v=%b O=%b err=%b cnt=%0d, want all zero",
               out_valid_a, o_a, err_a, cnt_a);
    end
    n_checks++;
    if ({out_valid_b, o_b, err_b, cnt_b} !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_b: got v=%b O=%b err=%b cnt=%0d, want all zero",
               out_valid_b, o_b, err_b, cnt_b);
    end
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_o [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 2'(3 - i), 1, 0);
      tick();
      n_checks++;
      if (out_valid_a !== 1'b1 || o_a !== exp_o[i] || o_b !== exp_o[i]) begin
        n_fail++;
        $display("FAIL b2b_%0d: got v=%b O=%b/%b want v=1 O=%b", i, out_valid_a, o_a, o_b,
                 exp_o[i]);
      end
    end
    drive(0, 0, 2'b00, 1, 0);
    tick();
    n_checks++;
    if (out_valid_a !== 1'b0 || o_a !== 4'b0000) begin
      n_fail++;
      $display("FAIL b2b_drain: got v=%b O=%b want v=0 O=0000", out_valid_a, o_a);
    end
  endtask

  task automatic test_backpressure();
    drive(1, 1, 2'b10, 1, 0);
    tick();
    drive(1, 1, 2'b11, 0, 0);
    for (int i = 0; i < 5; i++) begin
      #2;
      n_checks++;
      if (in_ready_a !== 1'b0 || o_a !== 4'b0010 || out_valid_a !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_%0d: got rdy=%b v=%b O=%b want rdy=0 v=1 O=0010", i, in_ready_a,
                 out_valid_a, o_a);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    n_checks++;
    if (in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL release_ready: got %b want 1", in_ready_a);
    end
    tick();
    n_checks++;
    if (o_a !== 4'b0001 || out_valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL release_load: got v=%b O=%b want v=1 O=0001", out_valid_a, o_a);
    end
    drive(0, 0, 2'b00, 1, 0);
    tick();
  endtask

  task automatic test_errors();
    logic [2:0] codes [3] = '{3'b000, 3'b011, 3'b010};
    for (int i = 0; i < 3; i++) begin
      drive(1, codes[i][2], codes[i][1:0], 1, 0);
      tick();
      n_checks++;
      if (out_valid_a !== 1'b0 || o_a !== 4'b0000) begin
        n_fail++;
        $display("FAIL err_fwd_%0d: got v=%b O=%b want v=0 O=0000", i, out_valid_a, o_a);
      end
    end
    n_checks++;
    if (cnt_a !== 8'd3 || err_a !== 1'b1 || cnt_b !== 2'd3 || err_b !== 1'b1) begin
      n_fail++;
      $display("FAIL err_count: got cnt=%0d/%0d err=%b/%b want 3/3 1/1", cnt_a, cnt_b,
               err_a, err_b);
    end
    drive(0, 0, 2'b00, 1, 1);
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (cnt_a !== 8'd0 || err_a !== 1'b0 || cnt_b !== 2'd0 || err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got cnt=%0d/%0d err=%b/%b want 0/0 0/0", cnt_a, cnt_b,
               err_a, err_b);
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 2'(i), 1, 0);
      tick();
    end
    n_checks++;
    if (cnt_b !== 2'd3 || cnt_a !== 8'd5) begin
      n_fail++;
      $display("FAIL saturate: got cnt2=%0d cnt8=%0d want 3 and 5", cnt_b, cnt_a);
    end
    drive(0, 0, 2'b00, 1, 1);
    tick();
  endtask

  task automatic test_clr_collision();
    drive(1, 0, 2'b00, 1, 0);
    tick();
    tick();
    n_checks++;
    if (cnt_a !== 8'd2) begin
      n_fail++;
      $display("FAIL collide_pre: got cnt=%0d want 2", cnt_a);
    end
    drive(1, 0, 2'b01, 1, 1);
    tick();
    n_checks++;
    if (cnt_a !== 8'd0 || err_a !== 1'b0 || cnt_b !== 2'd0 || err_b !== 1'b0) begin
      n_fail++;
      $display("FAIL collide: got cnt=%0d/%0d err=%b/%b want 0/0 0/0", cnt_a, cnt_b, err_a,
               err_b);
    end
    drive(0, 0, 2'b00, 1, 0);
  endtask

  task automatic test_reset_full();
    drive(1, 1, 2'b00, 0, 0);
    tick();
    drive(0, 0, 2'b00, 0, 0);
    n_checks++;
    if (o_a !== 4'b1000 || out_valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rstfull_pre: got v=%b O=%b want v=1 O=1000", out_valid_a, o_a);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (out_valid_a !== 1'b0 || o_a !== 4'b0000 || in_ready_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rstfull_async: got v=%b O=%b rdy=%b want v=0 O=0000 rdy=1", out_valid_a,
               o_a, in_ready_a);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    drive(1, 1, 2'b11, 1, 0);
    tick();
    n_checks++;
    if (o_a !== 4'b0001 || out_valid_a !== 1'b1) begin
      n_fail++;
      $display("FAIL rstfull_after: got v=%b O=%b want v=1 O=0001", out_valid_a, o_a);
    end
    drive(0, 0, 2'b00, 1, 0);
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 15) == 0));
      #1;
      n_checks++;
      if (in_ready_a !== (!m_valid || out_ready) || in_ready_b !== in_ready_a) begin
        n_fail++;
        $display("FAIL rand_ready_%0d: got %b/%b want %b", i, in_ready_a, in_ready_b,
                 !m_valid || out_ready);
      end
      tick();
      n_checks++;
      if (out_valid_a !== m_valid || o_a !== 4'(m_o) || err_a !== m_err ||
          cnt_a !== 8'(m_cnt8) || out_valid_b !== m_valid || o_b !== 4'(m_o) ||
          err_b !== m_err || cnt_b !== 2'(m_cnt2)) begin
        n_fail++;
        $display("FAIL rand_state_%0d: got v=%b O=%b err=%b cnt=%0d cnt2=%0d want v=%b O=%0d err=%b cnt=%0d cnt2=%0d",
                 i, out_valid_a, o_a, err_a, cnt_a, cnt_b, m_valid, m_o, m_err, m_cnt8,
                 m_cnt2);
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_errors();
    test_saturation();
    test_clr_collision();
    test_reset_full();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
